mic_level_detector: RTL and testbench
=====================================

Name: mic_level_detector

Overview:
- Reader on the audio-in side of Audio_Controller.
- Drains the ADC sample FIFO through the `audio_in_available` / `read_audio_in` handshake.
- Converts each stereo sample to a mono magnitude, averages it over a fixed window and applies hysteresis thresholds.
- Produces a `loud_active` level and a one-cycle `loud` trigger, so game logic can be driven by microphone input (e.g. a clap or shout to dodge).

Parameters:
- WIN_LOG2, 8, window length = 2^WIN_LOG2 samples (legal range 1..12).
- THRESH_ON, 16'h0800, `loud_active` sets when window level >= THRESH_ON.
- THRESH_OFF, 16'h0400, `loud_active` clears when window level < THRESH_OFF. Must be <= THRESH_ON.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  synchronous reset, active-low.
- enable  in  1  1 = accumulate/detect; 0 = drain and discard.
- audio_in_available  in  1  Audio_Controller FIFO has a sample.
- left_channel_audio_in  in  32  signed left sample, valid while available=1.
- right_channel_audio_in  in  32  signed right sample, valid while available=1.
- read_audio_in  out  1  one-cycle pop strobe to Audio_Controller.
- level  out  16  last completed window average magnitude.
- loud_active  out  1  hysteresis detector state.
- loud  out  1  one-cycle pulse on `loud_active` 0->1.
- sample_strobe  out  1  one-cycle pulse per accepted (accumulated) sample.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - Outputs: read_audio_in=0, level=0, loud_active=0, loud=0, sample_strobe=0.
  - Internal: accumulator=0, sample count=0, FSM=IDLE.
  - A reset mid-window discards the partial window.
- FSM, all outputs registered:
  - IDLE: if available=1, latch L and R into internal regs and go to POP; otherwise stay.
  - POP: read_audio_in=1 for exactly this cycle; go to SETTLE.
  - SETTLE: read_audio_in=0 for one cycle so the FIFO flag and data update; process the latched sample; go to IDLE.
  - Minimum 3 cycles per sample. Never two pops without an intervening IDLE check of available.
- Sample processing in SETTLE, only when enable=1:
  - mono = (L >>> 1) + (R >>> 1), 32-bit signed, arithmetic shifts.
  - mag = |mono|, saturating: mono = 32'h8000_0000 gives 32'h7FFF_FFFF.
  - m16 = mag[30:15].
  - acc += m16. Accumulator width is 16+WIN_LOG2 bits and never overflows.
  - sample_strobe=1 that cycle; count += 1.
- Window end: when count reaches 2^WIN_LOG2 in SETTLE:
  - level <= (acc + m16) >> WIN_LOG2, registered.
  - acc <= 0 and count <= 0.
  - Level is visible the cycle after SETTLE.
- Hysteresis is evaluated with the new level in the same cycle level updates:
  - if !loud_active and new level >= THRESH_ON, loud_active <= 1 and loud <= 1 for one cycle.
  - if loud_active and new level < THRESH_OFF, loud_active <= 0.
  - Otherwise hold.
  - loud is only ever high in a window-end cycle.
- enable=0:
  - The FIFO is still drained (IDLE/POP/SETTLE unchanged) so the ADC FIFO never overflows.
  - No accumulation and no sample_strobe.
  - acc and count are held at 0, loud_active <= 0, loud=0, level holds its last value.
- enable rising: a fresh window starts at count 0. An enable change during POP/SETTLE takes effect at the SETTLE processing decision.
- available dropping while in POP/SETTLE has no effect; the latched sample is still processed.

Test Plan:
- Reset then idle:
  - Stimulus: resetn=0 for 2 cycles, available=0.
  - Response: all outputs 0; read_audio_in never asserts.
- Quiet input:
  - Stimulus: enable=1, 256 samples L=R=32'h0100_0000, available held high.
  - Response: exactly 256 read_audio_in pulses, each 1 cycle and spaced 3 cycles apart; level=16'h0200; loud_active=0; loud never pulses.
- Loud input:
  - Stimulus: 256 samples L=R=32'h0800_0000, then 256 samples L=R=-32'h0800_0000.
  - Response: level=16'h1000 after each window; loud pulses exactly once, 1 cycle, at the first window end; loud_active stays 1.
- Hysteresis:
  - Stimulus: after loud, a window at m16=16'h0600, then a window at m16=16'h0300.
  - Response: loud_active stays 1 after the first (0x0600 >= OFF) and clears after the second (0x0300 < OFF).
- Saturation boundary:
  - Stimulus: 256 samples L=R=32'h8000_0000.
  - Response: level=16'hFFFF, loud_active=1, no accumulator wrap.
- Disable and mid-window reset:
  - Stimulus: enable=0 with 100 samples offered.
  - Response: 100 pops, no sample_strobe, loud_active=0, level held.
  - Stimulus: then enable=1, 128 loud samples, resetn=0 pulse, 256 quiet samples.
  - Response: level=16'h0200 with no carry-over from the partial window.

Source files
------------

// File: rtl/mic_level_detector.sv
// Microphone level detector: drains the Audio_Controller input FIFO, averages the
// mono magnitude over 2^WIN_LOG2 samples and flags loud windows with hysteresis.
module mic_level_detector #(
  parameter int unsigned WIN_LOG2   = 8,
  parameter logic [15:0] THRESH_ON  = 16'h0800,
  parameter logic [15:0] THRESH_OFF = 16'h0400
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        enable,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic [15:0] level,
  output logic        loud_active,
  output logic        loud,
  output logic        sample_strobe
);

  localparam int unsigned          ACC_W    = 16 + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0]  CNT_LAST = {WIN_LOG2{1'b1}};
  localparam logic [WIN_LOG2-1:0]  CNT_ONE  = WIN_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Mono magnitude with the single unrepresentable negation clamped.
  function automatic logic [31:0] mono_mag(input logic [31:0] l, input logic [31:0] r);
    logic signed [31:0] mono;
    mono = ($signed(l) >>> 1) + ($signed(r) >>> 1);
    if (mono == 32'sh8000_0000) begin
      mono_mag = 32'h7FFF_FFFF;
    end else if (mono[31]) begin
      mono_mag = $unsigned(-mono);
    end else begin
      mono_mag = $unsigned(mono);
    end
  endfunction

  state_t              state_q, state_d;
  logic [31:0]         l_q, l_d, r_q, r_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic                read_audio_in_q, read_audio_in_d;
  logic [15:0]         level_q, level_d;
  logic                loud_active_q, loud_active_d;
  logic                loud_q, loud_d;
  logic                sample_strobe_q, sample_strobe_d;

  logic [31:0]         mag_s;
  logic [15:0]         m16_s;
  logic [ACC_W-1:0]    acc_sum_s;
  logic [15:0]         new_level_s;
  logic                unused_mag_s;

  // Datapath for the latched sample: magnitude, running sum and window average.
  always_comb begin
    mag_s        = mono_mag(l_q, r_q);
    m16_s        = mag_s[30:15];
    acc_sum_s    = acc_q + ACC_W'(m16_s);
    new_level_s  = acc_sum_s[ACC_W-1:WIN_LOG2];
    unused_mag_s = ^{mag_s[31], mag_s[14:0]};
  end

  // Next-state logic for the FIFO handshake and the level/hysteresis tracker.
  always_comb begin
    state_d         = state_q;
    l_d             = l_q;
    r_d             = r_q;
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    read_audio_in_d = 1'b0;
    level_d         = level_q;
    loud_active_d   = loud_active_q;
    loud_d          = 1'b0;
    sample_strobe_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (audio_in_available) begin
          state_d         = POP;
          l_d             = left_channel_audio_in;
          r_d             = right_channel_audio_in;
          read_audio_in_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      POP:     state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // While disabled the FIFO keeps draining but the window is held empty.
    if (!enable) begin
      acc_d         = {ACC_W{1'b0}};
      cnt_d         = {WIN_LOG2{1'b0}};
      loud_active_d = 1'b0;
    end else if (state_q == SETTLE) begin
      sample_strobe_d = 1'b1;
      if (cnt_q == CNT_LAST) begin
        acc_d   = {ACC_W{1'b0}};
        cnt_d   = {WIN_LOG2{1'b0}};
        level_d = new_level_s;
        if (!loud_active_q && (new_level_s >= THRESH_ON)) begin
          loud_active_d = 1'b1;
          loud_d        = 1'b1;
        end else if (loud_active_q && (new_level_s < THRESH_OFF)) begin
          loud_active_d = 1'b0;
        end else begin
          loud_active_d = loud_active_q;
        end
      end else begin
        acc_d = acc_sum_s;
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q         <= IDLE;
      l_q             <= 32'h0000_0000;
      r_q             <= 32'h0000_0000;
      acc_q           <= {ACC_W{1'b0}};
      cnt_q           <= {WIN_LOG2{1'b0}};
      read_audio_in_q <= 1'b0;
      level_q         <= 16'h0000;
      loud_active_q   <= 1'b0;
      loud_q          <= 1'b0;
      sample_strobe_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      l_q             <= l_d;
      r_q             <= r_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      read_audio_in_q <= read_audio_in_d;
      level_q         <= level_d;
      loud_active_q   <= loud_active_d;
      loud_q          <= loud_d;
      sample_strobe_q <= sample_strobe_d;
    end
  end

  assign read_audio_in = read_audio_in_q;
  assign level         = level_q;
  assign loud_active   = loud_active_q;
  assign loud          = loud_q;
  assign sample_strobe = sample_strobe_q;

endmodule

// File: tb/tb_mic_level_detector.sv
// Scoreboard bench for mic_level_detector: expected window results are queued as
// samples are offered and compared when the DUT completes each window.
module tb_mic_level_detector;

  localparam int WIN = 256;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        audio_in_available = 1'b0;
  logic [31:0] left_channel_audio_in = 32'h0;
  logic [31:0] right_channel_audio_in = 32'h0;
  logic        read_audio_in;
  logic [15:0] level;
  logic        loud_active;
  logic        loud;
  logic        sample_strobe;

  mic_level_detector dut (
    .CLOCK_50               (CLOCK_50),
    .resetn                 (resetn),
    .enable                 (enable),
    .audio_in_available     (audio_in_available),
    .left_channel_audio_in  (left_channel_audio_in),
    .right_channel_audio_in (right_channel_audio_in),
    .read_audio_in          (read_audio_in),
    .level                  (level),
    .loud_active            (loud_active),
    .loud                   (loud),
    .sample_strobe          (sample_strobe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [15:0] lvl;
    logic        act;
    logic        pulse;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  int     pop_cnt = 0;
  int     strobe_cnt = 0;
  int     loud_cnt = 0;
  int     win_seen = 0;
  longint m_sum = 0;
  int     m_cnt = 0;
  logic   m_active = 1'b0;
  logic [15:0] m_level = 16'h0;
  int     snap_pop, snap_strobe;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_m16(input logic [31:0] l, input logic [31:0] r);
    longint      mono;
    logic [63:0] mag;
    mono = (longint'($signed(l)) >>> 1) + (longint'($signed(r)) >>> 1);
    if (mono < 0) mono = -mono;
    if (mono > 64'sh7FFF_FFFF) mono = 64'sh7FFF_FFFF;
    mag = mono;
    return mag[30:15];
  endfunction

  // Window monitor: each WIN-th sample strobe is a window end.
  always @(negedge CLOCK_50) begin
    if (read_audio_in) pop_cnt++;
    if (loud) loud_cnt++;
    if (sample_strobe) begin
      strobe_cnt++;
      win_seen++;
      if (win_seen == WIN) begin
        win_seen = 0;
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_window", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("win_level", {16'h0, level}, {16'h0, mon_e.lvl});
          check_eq("win_active", {31'h0, loud_active}, {31'h0, mon_e.act});
          check_eq("win_loud", {31'h0, loud}, {31'h0, mon_e.pulse});
        end
      end else begin
        check_eq("loud_mid_window", {31'h0, loud}, 32'd0);
      end
    end else if (loud) begin
      check_eq("loud_stray", {31'h0, loud}, 32'd0);
    end
  end

  task automatic do_reset();
    @(negedge CLOCK_50);
    resetn = 1'b0;
    audio_in_available = 1'b0;
    repeat (2) begin
      @(negedge CLOCK_50);
      check_eq("rst_read", {31'h0, read_audio_in}, 32'd0);
      check_eq("rst_level", {16'h0, level}, 32'd0);
      check_eq("rst_active", {31'h0, loud_active}, 32'd0);
      check_eq("rst_loud", {31'h0, loud}, 32'd0);
      check_eq("rst_strobe", {31'h0, sample_strobe}, 32'd0);
    end
    win_seen = 0;
    m_sum = 0;
    m_cnt = 0;
    m_active = 1'b0;
    m_level = 16'h0;
    resetn = 1'b1;
  endtask

  // Offer n identical samples, push expected window results, check pop spacing.
  task automatic send(input int n, input logic [31:0] l, input logic [31:0] r);
    logic [15:0] m16, lvl;
    logic        pulse;
    int          got, gap, budget;
    m16 = ref_m16(l, r);
    for (int i = 0; i < n; i++) begin
      if (enable) begin
        m_sum += m16;
        m_cnt++;
        if (m_cnt == WIN) begin
          lvl = 16'(m_sum >> 8);
          pulse = 1'b0;
          if (!m_active && lvl >= 16'h0800) begin
            m_active = 1'b1;
            pulse = 1'b1;
          end else if (m_active && lvl < 16'h0400) begin
            m_active = 1'b0;
          end
          exp_q.push_back('{lvl: lvl, act: m_active, pulse: pulse});
          m_level = lvl;
          m_sum = 0;
          m_cnt = 0;
        end
      end else begin
        m_active = 1'b0;
        m_sum = 0;
        m_cnt = 0;
      end
    end
    got = 0;
    gap = 0;
    budget = n * 3 + 20;
    @(negedge CLOCK_50);
    left_channel_audio_in = l;
    right_channel_audio_in = r;
    audio_in_available = 1'b1;
    while (got < n && budget > 0) begin
      @(negedge CLOCK_50);
      budget--;
      gap++;
      if (read_audio_in) begin
        if (got > 0) check_eq("pop_gap", gap, 32'd3);
        gap = 0;
        got++;
        if (got == n) audio_in_available = 1'b0;
      end
    end
    audio_in_available = 1'b0;
    if (got != n) check_eq("pop_timeout", got, n);
    repeat (3) @(negedge CLOCK_50);
    check_eq("level_track", {16'h0, level}, {16'h0, m_level});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    repeat (5) @(negedge CLOCK_50);
    check_eq("idle_no_pop", pop_cnt, 32'd0);

    enable = 1'b1;
    send(WIN, 32'h0100_0000, 32'h0100_0000);
    check_eq("quiet_pops", pop_cnt, WIN);
    check_eq("quiet_active", {31'h0, loud_active}, 32'd0);
    check_eq("quiet_loud_cnt", loud_cnt, 32'd0);

    send(WIN, 32'h0800_0000, 32'h0800_0000);
    send(WIN, 32'hF800_0000, 32'hF800_0000);
    check_eq("loud_cnt_once", loud_cnt, 32'd1);
    check_eq("loud_active_held", {31'h0, loud_active}, 32'd1);

    send(WIN, 32'h0300_0000, 32'h0300_0000);
    check_eq("hyst_hold", {31'h0, loud_active}, 32'd1);
    send(WIN, 32'h0180_0000, 32'h0180_0000);
    check_eq("hyst_clear", {31'h0, loud_active}, 32'd0);

    send(WIN, 32'h0200_0000, 32'hFF00_0000);

    send(WIN, 32'h8000_0000, 32'h8000_0000);
    check_eq("sat_level", {16'h0, level}, 32'h0000_FFFF);
    check_eq("sat_active", {31'h0, loud_active}, 32'd1);
    check_eq("sat_loud_cnt", loud_cnt, 32'd2);

    @(negedge CLOCK_50);
    enable = 1'b0;
    win_seen = 0;
    snap_pop = pop_cnt;
    snap_strobe = strobe_cnt;
    send(100, 32'h0800_0000, 32'h0800_0000);
    check_eq("dis_pops", pop_cnt - snap_pop, 32'd100);
    check_eq("dis_strobes", strobe_cnt - snap_strobe, 32'd0);
    check_eq("dis_active", {31'h0, loud_active}, 32'd0);
    check_eq("dis_level_held", {16'h0, level}, 32'h0000_FFFF);

    @(negedge CLOCK_50);
    enable = 1'b1;
    send(WIN / 2, 32'h0800_0000, 32'h0800_0000);
    do_reset();
    send(WIN, 32'h0100_0000, 32'h0100_0000);
    check_eq("post_rst_level", {16'h0, level}, 32'h0000_0200);
    check_eq("post_rst_active", {31'h0, loud_active}, 32'd0);

    check_eq("sb_drained", exp_q.size(), 32'd0);
    check_eq("final_loud_cnt", loud_cnt, 32'd2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
